// File: rtl/rie_pkg.sv
// Shared types and helpers for reg_instr_engine.
// Optional build macro RIE_ZERO_REG_EN (used in rie_regfile) hard-wires register 0 to zero.
package rie_pkg;

    typedef enum logic [2:0] {
        OP_LDI  = 3'b000,
        OP_RD1  = 3'b001,
        OP_RD2  = 3'b010,
        OP_RDW1 = 3'b011,
        OP_RDW2 = 3'b100,
        OP_ADD  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SHF  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        ALU  = 3'd2,
        WB   = 3'd3,
        RESP = 3'd4
    } state_e;

    // Shift-amount width for a given data width; instantiated as SHAMT_W in the top.
    function automatic int shamt_w(input int data_w);
        return $clog2(data_w);
    endfunction

    function automatic logic is_alu(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHF);
    endfunction

    function automatic logic writes_imm_late(input op_e op);
        return (op == OP_RDW1) || (op == OP_RDW2);
    endfunction

endpackage

// File: rtl/rie_regfile.sv
// 2-read/1-write register file with asynchronous clear and combinational reads.
// Define RIE_ZERO_REG_EN to make register 0 read as zero and ignore writes to it.
module rie_regfile
    import rie_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int NREG = 2 ** ADDR_W;
`ifdef RIE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (ZERO_REG && (gi == 0)) begin : g_zero
                assign mem_q[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
                        r_q <= wdata_i;
                    end
                end
                assign mem_q[gi] = r_q;
            end
        end
    endgenerate

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/reg_instr_engine.sv
// Single-issue register instruction engine with valid/ready command and response ports.
// Build option RIE_ZERO_REG_EN (see rie_regfile) makes register 0 a constant zero.
module reg_instr_engine
    import rie_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int ALU_LAT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              busy
);

    localparam int SHAMT_W = shamt_w(DATA_W);
    localparam int CNT_W   = $clog2(ALU_LAT + 1);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
    logic [DATA_W-1:0] imm_q, opa_q, opb_q, res_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_ready_q, rsp_valid_q, busy_q;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data2_q;

    logic [DATA_W-1:0] rdata1_d, rdata2_d, alu_d, wdata_d;
    logic              we_d;

    rie_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we_d),
        .waddr_i  (rd_q),
        .wdata_i  (wdata_d),
        .raddr1_i (ra_q),
        .raddr2_i (rb_q),
        .rdata1_o (rdata1_d),
        .rdata2_o (rdata2_d)
    );

    always_comb begin
        alu_d = '0;
        case (op_q)
            OP_ADD: alu_d = opa_q + opb_q;
            OP_SUB: alu_d = opa_q - opb_q;
            OP_SHF: begin
                // Kept as separate assignments so the right shift stays signed.
                if (imm_q[DATA_W-1]) alu_d = $signed(opa_q) >>> imm_q[SHAMT_W-1:0];
                else                 alu_d = opa_q << imm_q[SHAMT_W-1:0];
            end
            default: alu_d = '0;
        endcase
    end

    // LDI writes during ACC; read-then-write and ALU ops write in WB, after their reads.
    always_comb begin
        we_d    = 1'b0;
        wdata_d = imm_q;
        if ((state_q == ACC) && (op_q == OP_LDI)) begin
            we_d = 1'b1;
        end else if (state_q == WB) begin
            if (writes_imm_late(op_q)) begin
                we_d = 1'b1;
            end else if (is_alu(op_q)) begin
                we_d    = 1'b1;
                wdata_d = res_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LDI;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= op_e'(cmd_op);
                        ra_q        <= cmd_ra;
                        rb_q        <= cmd_rb;
                        rd_q        <= cmd_rd;
                        imm_q       <= cmd_imm;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ACC;
                    end
                end
                ACC: begin
                    opa_q   <= rdata1_d;
                    opb_q   <= rdata2_d;
                    cnt_q   <= '0;
                    state_q <= is_alu(op_q) ? ALU : WB;
                end
                ALU: begin
                    // Capture ALU_LAT cycles into ALU so the response lands at T+ALU_LAT+3.
                    if (cnt_q == CNT_W'(ALU_LAT)) begin
                        res_q   <= alu_d;
                        state_q <= WB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WB: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                    case (op_q)
                        OP_LDI: begin
                            rsp_data1_q <= imm_q;
                            rsp_data2_q <= '0;
                        end
                        OP_RD1, OP_RDW1: begin
                            rsp_data1_q <= opa_q;
                            rsp_data2_q <= '0;
                        end
                        OP_RD2, OP_RDW2: begin
                            rsp_data1_q <= opa_q;
                            rsp_data2_q <= opb_q;
                        end
                        default: begin
                            rsp_data1_q <= res_q;
                            rsp_data2_q <= '0;
                        end
                    endcase
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_instr_engine.sv
// Directed bench for reg_instr_engine with a behavioural register-file model and per-cycle checker.
// Honours RIE_ZERO_REG_EN when the design is built with it.
`timescale 1ns/1ps
module tb_reg_instr_engine;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int ALU_LAT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data1, rsp_data2;
    logic              busy;

    reg_instr_engine #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data1 (rsp_data1),
        .rsp_data2 (rsp_data2),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;
    logic exp_armed = 1'b0;
    logic [DATA_W-1:0] exp_d1 = '0, exp_d2 = '0;
    int   exp_lat = 0;
    int   t_acc = 0;
    logic [DATA_W-1:0] mr [2**ADDR_W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rdm(input logic [ADDR_W-1:0] a);
`ifdef RIE_ZERO_REG_EN
        if (a == '0) return '0;
`endif
        return mr[a];
    endfunction

    task automatic wrm(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
`ifdef RIE_ZERO_REG_EN
        if (a == '0) return;
`endif
        mr[a] = v;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2**ADDR_W; i++) mr[i] = '0;
    endtask

    // Expected response, latency and register update for one instruction.
    task automatic model(input logic [2:0] op, input logic [ADDR_W-1:0] ra, rb, rd,
                         input logic [DATA_W-1:0] imm);
        logic [DATA_W-1:0] a, b, v;
        logic wr;
        a = rdm(ra);
        b = rdm(rb);
        v = imm;
        wr = 1'b0;
        exp_d1 = '0;
        exp_d2 = '0;
        exp_lat = 2;
        case (op)
            3'd0: begin exp_d1 = imm; wr = 1'b1; end
            3'd1: exp_d1 = a;
            3'd2: begin exp_d1 = a; exp_d2 = b; end
            3'd3: begin exp_d1 = a; wr = 1'b1; end
            3'd4: begin exp_d1 = a; exp_d2 = b; wr = 1'b1; end
            default: begin
                if (op == 3'd5)      v = a + b;
                else if (op == 3'd6) v = a - b;
                else if (imm[DATA_W-1]) v = $signed(a) >>> imm[3:0];
                else                    v = a << imm[3:0];
                exp_d1 = v;
                wr = 1'b1;
                exp_lat = ALU_LAT + 3;
            end
        endcase
        if (wr) wrm(rd, v);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_vs_ready", busy, !cmd_ready);
            if (!exp_armed) begin
                check("rsp_valid_idle", rsp_valid, 1'b0);
            end else begin
                check("ready_low_in_flight", cmd_ready, 1'b0);
                if (rsp_valid) begin
                    check("rsp_data1", rsp_data1, exp_d1);
                    check("rsp_data2", rsp_data2, exp_d2);
                end
            end
        end
    end

    task automatic start(input logic [2:0] op, input logic [ADDR_W-1:0] ra, rb, rd,
                         input logic [DATA_W-1:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        t_acc     = cyc;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_ra    = ADDR_W'($urandom);
        cmd_rb    = ADDR_W'($urandom);
        cmd_rd    = ADDR_W'($urandom);
        cmd_imm   = DATA_W'($urandom);
        model(op, ra, rb, rd, imm);
        exp_armed = 1'b1;
    endtask

    task automatic finish(input int hold, input logic pin_en, input logic [DATA_W-1:0] pin);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < ALU_LAT + 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
        end else begin
            check("rsp_latency", cyc - t_acc, exp_lat);
            if (pin_en) check("pin_data1", rsp_data1, pin);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_rsp_valid", rsp_valid, 1'b1);
                check("hold_cmd_ready", cmd_ready, 1'b0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            exp_armed = 1'b0;
            check("post_hs_valid", rsp_valid, 1'b0);
            check("post_hs_ready", cmd_ready, 1'b1);
        end
        $display("txn: lat=%0d data1=%h data2=%h", cyc - t_acc, exp_d1, exp_d2);
    endtask

    task automatic run(input logic [2:0] op, input logic [ADDR_W-1:0] ra, rb, rd,
                       input logic [DATA_W-1:0] imm, input int hold,
                       input logic pin_en, input logic [DATA_W-1:0] pin);
        start(op, ra, rb, rd, imm);
        finish(hold, pin_en, pin);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_data1", rsp_data1, 16'h0000);
        check("reset_data2", rsp_data2, 16'h0000);
        check("reset_busy", busy, 1'b0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run(3'd2, 5'd3, 5'd31, 5'd0, 16'h0000, 0, 1'b1, 16'h0000);
        run(3'd0, 5'd0, 5'd0, 5'd7, 16'h1234, 0, 1'b1, 16'h1234);
        run(3'd1, 5'd7, 5'd0, 5'd0, 16'h0000, 0, 1'b1, 16'h1234);

        run(3'd0, 5'd0, 5'd0, 5'd5, 16'd9, 0, 1'b0, 16'h0);
        run(3'd3, 5'd5, 5'd0, 5'd5, 16'd42, 0, 1'b1, 16'd9);
        run(3'd1, 5'd5, 5'd0, 5'd0, 16'h0000, 0, 1'b1, 16'd42);

        run(3'd0, 5'd0, 5'd0, 5'd1, 16'h7FFF, 0, 1'b0, 16'h0);
        run(3'd0, 5'd0, 5'd0, 5'd2, 16'h0001, 0, 1'b0, 16'h0);
        run(3'd5, 5'd1, 5'd2, 5'd3, 16'h0000, 0, 1'b1, 16'h8000);
        run(3'd1, 5'd3, 5'd0, 5'd0, 16'h0000, 0, 1'b1, 16'h8000);

        run(3'd0, 5'd0, 5'd0, 5'd4, 16'h8000, 0, 1'b0, 16'h0);
        run(3'd7, 5'd4, 5'd0, 5'd8, 16'h8003, 5, 1'b1, 16'hF000);
        run(3'd0, 5'd0, 5'd0, 5'd4, 16'h0001, 0, 1'b0, 16'h0);
        run(3'd7, 5'd4, 5'd0, 5'd8, 16'h0004, 0, 1'b1, 16'h0010);

        run(3'd6, 5'd9, 5'd2, 5'd10, 16'h0000, 0, 1'b1, 16'hFFFF);
        run(3'd4, 5'd10, 5'd8, 5'd10, 16'h00AA, 2, 1'b1, 16'hFFFF);
        run(3'd1, 5'd10, 5'd0, 5'd0, 16'h0000, 0, 1'b1, 16'h00AA);

        // Abort a SUB while it sits in the ALU state.
        run(3'd0, 5'd0, 5'd0, 5'd11, 16'd20, 0, 1'b0, 16'h0);
        start(3'd6, 5'd11, 5'd2, 5'd6, 16'h0000);
        repeat (5) @(negedge clk);
        check("busy_in_alu", busy, 1'b1);
        rst_n     = 1'b0;
        exp_armed = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < ALU_LAT + 6; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("abort_no_rsp", seen, 1'b0);
        run(3'd1, 5'd6, 5'd11, 5'd0, 16'h0000, 0, 1'b1, 16'h0000);

        run(3'd0, 5'd0, 5'd0, 5'd0, 16'd5, 0, 1'b1, 16'd5);
`ifdef RIE_ZERO_REG_EN
        run(3'd1, 5'd0, 5'd0, 5'd0, 16'h0000, 0, 1'b1, 16'd0);
`else
        run(3'd1, 5'd0, 5'd0, 5'd0, 16'h0000, 0, 1'b1, 16'd5);
`endif
        run(3'd0, 5'd0, 5'd0, 5'd12, 16'd3, 0, 1'b0, 16'h0);
        run(3'd0, 5'd0, 5'd0, 5'd13, 16'd4, 0, 1'b0, 16'h0);
        run(3'd5, 5'd12, 5'd13, 5'd0, 16'h0000, 0, 1'b1, 16'd7);
`ifdef RIE_ZERO_REG_EN
        run(3'd2, 5'd0, 5'd12, 5'd0, 16'h0000, 0, 1'b1, 16'd0);
`else
        run(3'd2, 5'd0, 5'd12, 5'd0, 16'h0000, 0, 1'b1, 16'd7);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
